arp_responder_axis: RTL and testbench

Parametrised ARP responder for the UDP stack. Sits between the Ethernet MAC receive stream (preamble/FCS already stripped) and the MAC transmit arbiter. Parses every incoming frame at a configurable AXI-Stream width of 1–8 bytes per beat with full TREADY/TLAST/TKEEP handshaking. Answers IPv4 ARP requests addressed to the local IP with a single reply frame, optionally padded to the 60-byte Ethernet minimum, and counts replies and dropped requests.

---
 rtl/arp_responder_axis.sv | 203 ++++++++++++++++++++
 tb/tb_arp_responder_axis.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_responder_axis.sv
// ARP responder: parses the MAC RX stream and answers IPv4 ARP requests for the
// local address with one reply frame on the TX stream.
module arp_responder_axis #(
  parameter int          P_DATA_BYTES = 1,
  parameter logic [47:0] P_LOCAL_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [31:0] P_LOCAL_IPV4 = 32'hC0_A8_01_0A,
  parameter bit          P_PAD_TO_60  = 1'b1
) (
  input  logic                      I_CLK,
  input  logic                      I_RESET_N,
  output logic                      S_AXIS_TREADY,
  input  logic                      S_AXIS_TVALID,
  input  logic [8*P_DATA_BYTES-1:0] S_AXIS_TDATA,
  input  logic [P_DATA_BYTES-1:0]   S_AXIS_TKEEP,
  input  logic                      S_AXIS_TLAST,
  input  logic                      S_AXIS_TUSER,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TVALID,
  output logic [8*P_DATA_BYTES-1:0] M_AXIS_TDATA,
  output logic [P_DATA_BYTES-1:0]   M_AXIS_TKEEP,
  output logic                      M_AXIS_TLAST,
  output logic                      M_AXIS_TUSER,
  output logic [15:0]               O_REPLY_CNT,
  output logic [15:0]               O_DROP_CNT
);

  localparam int DW         = 8 * P_DATA_BYTES;
  localparam int REPLY_LEN  = P_PAD_TO_60 ? 60 : 42;
  localparam int N_BEATS    = (REPLY_LEN + P_DATA_BYTES - 1) / P_DATA_BYTES;
  localparam int LAST_BYTES = REPLY_LEN - (N_BEATS - 1) * P_DATA_BYTES;
  localparam logic [P_DATA_BYTES-1:0] LAST_KEEP = P_DATA_BYTES'((1 << LAST_BYTES) - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  // Fixed ARP/Ethernet header bytes of a request (offsets 12..21)
  function automatic logic [7:0] hdr_byte(input int off);
    case (off)
      12: hdr_byte = 8'h08;
      13: hdr_byte = 8'h06;
      15: hdr_byte = 8'h01;
      16: hdr_byte = 8'h08;
      18: hdr_byte = 8'h06;
      19: hdr_byte = 8'h04;
      21: hdr_byte = 8'h01;
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] reply_byte(input int off, input logic [47:0] sha,
                                            input logic [31:0] spa);
    if (off < 6)                    reply_byte = 8'(sha >> (8 * (5 - off)));
    else if (off < 12)              reply_byte = 8'(P_LOCAL_MAC >> (8 * (11 - off)));
    else if (off < 21)              reply_byte = hdr_byte(off);
    else if (off == 21)             reply_byte = 8'h02;
    else if (off < 28)              reply_byte = 8'(P_LOCAL_MAC >> (8 * (27 - off)));
    else if (off < 32)              reply_byte = 8'(P_LOCAL_IPV4 >> (8 * (31 - off)));
    else if (off < 38)              reply_byte = 8'(sha >> (8 * (37 - off)));
    else if (off < 42)              reply_byte = 8'(spa >> (8 * (41 - off)));
    else                            reply_byte = 8'h00;
  endfunction

  logic        s_rdy_q, s_rdy_d;
  logic [5:0]  cnt_q, cnt_d;
  // mis: 0 not broadcast, 1 not local MAC, 2 ethertype, 3 htype/ptype/hlen/plen, 4 oper, 5 tpa
  logic [5:0]  mis_q, mis_d;
  logic [47:0] sha_q, sha_d, rsha_q, rsha_d;
  logic [31:0] spa_q, spa_d, rspa_q, rspa_d;
  state_t      state_q, state_d;
  logic [5:0]  beat_q, beat_d;
  logic [15:0] reply_cnt_q, reply_cnt_d, drop_cnt_q, drop_cnt_d;
  logic        req_valid;
  logic [7:0]  b;
  int          tot, off, sh;

  assign s_rdy_d = 1'b1;

  always_comb begin
    cnt_d     = cnt_q;
    mis_d     = mis_q;
    sha_d     = sha_q;
    spa_d     = spa_q;
    req_valid = 1'b0;
    tot       = int'(cnt_q);
    off       = 0;
    sh        = 0;
    b         = '0;
    if (S_AXIS_TVALID && s_rdy_q) begin
      for (int i = 0; i < P_DATA_BYTES; i++) begin
        if (S_AXIS_TKEEP[i]) begin
          off = int'(cnt_q) + i;
          b   = 8'(S_AXIS_TDATA >> (8 * i));
          tot = tot + 1;
          if (off < 6) begin
            if (b != 8'hFF) mis_d[0] = 1'b1;
            if (b != 8'(P_LOCAL_MAC >> (8 * (5 - off)))) mis_d[1] = 1'b1;
          end else if (off == 12 || off == 13) begin
            if (b != hdr_byte(off)) mis_d[2] = 1'b1;
          end else if (off >= 14 && off <= 19) begin
            if (b != hdr_byte(off)) mis_d[3] = 1'b1;
          end else if (off == 20 || off == 21) begin
            if (b != hdr_byte(off)) mis_d[4] = 1'b1;
          end else if (off >= 22 && off <= 27) begin
            sh    = 8 * (27 - off);
            sha_d = (sha_d & ~(48'hFF << sh)) | (48'(b) << sh);
          end else if (off >= 28 && off <= 31) begin
            sh    = 8 * (31 - off);
            spa_d = (spa_d & ~(32'hFF << sh)) | (32'(b) << sh);
          end else if (off >= 38 && off <= 41) begin
            if (b != 8'(P_LOCAL_IPV4 >> (8 * (41 - off)))) mis_d[5] = 1'b1;
          end
        end
      end
      if (S_AXIS_TLAST) begin
        req_valid = !S_AXIS_TUSER && (tot >= 42) && !(mis_d[0] && mis_d[1]) &&
                    (mis_d[5:2] == 4'b0);
        cnt_d = '0;
        mis_d = '0;
      end else begin
        cnt_d = (tot > 42) ? 6'd42 : 6'(tot);
      end
    end
  end

  // A request arriving while a reply is in flight is dropped, not queued
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    rsha_d      = rsha_q;
    rspa_d      = rspa_q;
    reply_cnt_d = reply_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (req_valid) begin
      if (state_q == IDLE) state_d = LOAD;
      else                 drop_cnt_d = drop_cnt_q + 16'd1;
    end
    case (state_q)
      LOAD: begin
        rsha_d  = sha_q;
        rspa_d  = spa_q;
        beat_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (M_AXIS_TREADY) begin
          if (int'(beat_q) == N_BEATS - 1) begin
            state_d     = IDLE;
            beat_d      = '0;
            reply_cnt_d = reply_cnt_q + 16'd1;
          end else begin
            beat_d = beat_q + 6'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    M_AXIS_TDATA = '0;
    for (int i = 0; i < P_DATA_BYTES; i++) begin
      if (state_q == SEND && (int'(beat_q) * P_DATA_BYTES + i) < REPLY_LEN)
        M_AXIS_TDATA = M_AXIS_TDATA |
          (DW'(reply_byte(int'(beat_q) * P_DATA_BYTES + i, rsha_q, rspa_q)) << (8 * i));
    end
  end

  assign M_AXIS_TVALID = (state_q == SEND);
  assign M_AXIS_TLAST  = (state_q == SEND) && (int'(beat_q) == N_BEATS - 1);
  assign M_AXIS_TKEEP  = (state_q != SEND) ? '0 : (M_AXIS_TLAST ? LAST_KEEP : '1);
  assign M_AXIS_TUSER  = 1'b0;
  assign S_AXIS_TREADY = s_rdy_q;
  assign O_REPLY_CNT   = reply_cnt_q;
  assign O_DROP_CNT    = drop_cnt_q;

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      s_rdy_q     <= 1'b0;
      cnt_q       <= '0;
      mis_q       <= '0;
      sha_q       <= '0;
      spa_q       <= '0;
      rsha_q      <= '0;
      rspa_q      <= '0;
      state_q     <= IDLE;
      beat_q      <= '0;
      reply_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      s_rdy_q     <= s_rdy_d;
      cnt_q       <= cnt_d;
      mis_q       <= mis_d;
      sha_q       <= sha_d;
      spa_q       <= spa_d;
      rsha_q      <= rsha_d;
      rspa_q      <= rspa_d;
      state_q     <= state_d;
      beat_q      <= beat_d;
      reply_cnt_q <= reply_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_arp_responder_axis.sv
// Directed bench for arp_responder_axis: a 1-byte padded instance and an 8-byte unpadded one.
module tb_arp_responder_axis;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_rdy_a, m_vld_a, m_last_a, m_user_a;
  logic        s_vld_a = 1'b0, s_last_a = 1'b0, s_user_a = 1'b0, m_rdy_a = 1'b1;
  logic [7:0]  s_data_a = '0, m_data_a;
  logic [0:0]  s_keep_a = 1'b1, m_keep_a;
  logic [15:0] rcnt_a, dcnt_a;

  logic        s_rdy_b, m_vld_b, m_last_b, m_user_b;
  logic        s_vld_b = 1'b0, s_last_b = 1'b0, s_user_b = 1'b0, m_rdy_b = 1'b1;
  logic [63:0] s_data_b = '0, m_data_b;
  logic [7:0]  s_keep_b = '0, m_keep_b;
  logic [15:0] rcnt_b, dcnt_b;

  arp_responder_axis #(.P_DATA_BYTES(1), .P_PAD_TO_60(1'b1)) dut_a (
    .I_CLK(clk), .I_RESET_N(rst_n),
    .S_AXIS_TREADY(s_rdy_a), .S_AXIS_TVALID(s_vld_a), .S_AXIS_TDATA(s_data_a),
    .S_AXIS_TKEEP(s_keep_a), .S_AXIS_TLAST(s_last_a), .S_AXIS_TUSER(s_user_a),
    .M_AXIS_TREADY(m_rdy_a), .M_AXIS_TVALID(m_vld_a), .M_AXIS_TDATA(m_data_a),
    .M_AXIS_TKEEP(m_keep_a), .M_AXIS_TLAST(m_last_a), .M_AXIS_TUSER(m_user_a),
    .O_REPLY_CNT(rcnt_a), .O_DROP_CNT(dcnt_a));

  arp_responder_axis #(.P_DATA_BYTES(8), .P_PAD_TO_60(1'b0)) dut_b (
    .I_CLK(clk), .I_RESET_N(rst_n),
    .S_AXIS_TREADY(s_rdy_b), .S_AXIS_TVALID(s_vld_b), .S_AXIS_TDATA(s_data_b),
    .S_AXIS_TKEEP(s_keep_b), .S_AXIS_TLAST(s_last_b), .S_AXIS_TUSER(s_user_b),
    .M_AXIS_TREADY(m_rdy_b), .M_AXIS_TVALID(m_vld_b), .M_AXIS_TDATA(m_data_b),
    .M_AXIS_TKEEP(m_keep_b), .M_AXIS_TLAST(m_last_b), .M_AXIS_TUSER(m_user_b),
    .O_REPLY_CNT(rcnt_b), .O_DROP_CNT(dcnt_b));

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0]  req [0:41];
  logic [7:0]  frm [0:41];
  logic [7:0]  rep [0:59];
  logic [7:0]  got_a [0:63];
  logic        gk_a [0:63];
  logic        gl_a [0:63];
  logic [63:0] got_bd [0:15];
  logic [7:0]  got_bk [0:15];
  logic        got_bl [0:15];
  int nb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input int len, input bit tu);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      s_vld_a  = 1'b1;
      s_data_a = frm[k];
      s_last_a = (k == len - 1);
      s_user_a = (k == len - 1) ? tu : 1'b0;
    end
    @(posedge clk); #1;
    s_vld_a = 1'b0; s_last_a = 1'b0; s_user_a = 1'b0;
  endtask

  task automatic send_b(input int len);
    for (int j = 0; j * 8 < len; j++) begin
      @(negedge clk);
      s_vld_b  = 1'b1;
      s_data_b = '0;
      s_keep_b = '0;
      for (int i = 0; i < 8; i++) begin
        if (j * 8 + i < len) begin
          s_data_b[8*i +: 8] = frm[j*8+i];
          s_keep_b[i] = 1'b1;
        end
      end
      s_last_b = ((j + 1) * 8 >= len);
    end
    @(posedge clk); #1;
    s_vld_b = 1'b0; s_last_b = 1'b0; s_keep_b = '0;
  endtask

  task automatic collect_a(input int pct, output int n);
    bit hold, done;
    logic [7:0] hd;
    logic hl, hk;
    int cyc;
    n = 0; hold = 0; done = 0; cyc = 0; hd = '0; hl = 0; hk = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk("hold_data", 64'(m_data_a), 64'(hd));
        chk("hold_keep", 64'(m_keep_a), 64'(hk));
        chk("hold_last", 64'(m_last_a), 64'(hl));
      end
      m_rdy_a = (int'($urandom_range(99)) < pct);
      if (m_vld_a && m_rdy_a) begin
        if (n < 64) begin
          got_a[n] = m_data_a; gk_a[n] = m_keep_a[0]; gl_a[n] = m_last_a;
        end
        n++;
        done = m_last_a;
      end
      hold = m_vld_a && !m_rdy_a;
      hd = m_data_a; hl = m_last_a; hk = m_keep_a[0];
    end
    if (!done) chk("collect_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    m_rdy_a = 1'b1;
  endtask

  task automatic check_reply_a(input int n);
    chk("beats_a", 64'(n), 64'd60);
    for (int k = 0; k < 60; k++) begin
      chk($sformatf("byte_a[%0d]", k), 64'(got_a[k]), 64'(rep[k]));
      chk($sformatf("keep_a[%0d]", k), 64'(gk_a[k]), 64'd1);
      chk($sformatf("last_a[%0d]", k), 64'(gl_a[k]), 64'(k == 59));
    end
  endtask

  initial begin
    bit done;
    req = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
            8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hC0, 8'hA8, 8'h01, 8'h01, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h0A};
    for (int k = 0; k < 60; k++) rep[k] = 8'h00;
    rep[0:41] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h02, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h01, 8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04,
                  8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC0, 8'hA8,
                  8'h01, 8'h0A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hC0, 8'hA8,
                  8'h01, 8'h01};

    // Reset values
    #12;
    chk("rst_s_tready", 64'(s_rdy_a), 64'd0);
    chk("rst_m_tvalid", 64'(m_vld_a), 64'd0);
    chk("rst_m_tdata", 64'(m_data_a), 64'd0);
    chk("rst_m_tkeep", 64'(m_keep_a), 64'd0);
    chk("rst_m_tlast", 64'(m_last_a), 64'd0);
    chk("rst_m_tuser", 64'(m_user_a), 64'd0);
    chk("rst_reply_cnt", 64'(rcnt_a), 64'd0);
    chk("rst_drop_cnt", 64'(dcnt_a), 64'd0);
    chk("rst_m_tkeep_b", 64'(m_keep_b), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s_tready_after_rst", 64'(s_rdy_a), 64'd1);

    // Broadcast request, 1 byte per beat, padded reply, N+2 latency
    frm = req;
    send_a(42, 1'b0);
    chk("tvalid_n1", 64'(m_vld_a), 64'd0);
    @(posedge clk); #1;
    chk("tvalid_n2", 64'(m_vld_a), 64'd1);
    chk("first_byte", 64'(m_data_a), 64'h00);
    collect_a(100, nb);
    check_reply_a(nb);
    chk("reply_cnt_1", 64'(rcnt_a), 64'd1);
    chk("idle_after_last", 64'(m_vld_a), 64'd0);

    // Same request on the 8-byte, unpadded instance
    send_b(42);
    nb = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (m_vld_b) begin
        if (nb < 16) begin
          got_bd[nb] = m_data_b; got_bk[nb] = m_keep_b; got_bl[nb] = m_last_b;
        end
        nb++;
        done = m_last_b;
      end
    end
    @(posedge clk); #1;
    chk("beats_b", 64'(nb), 64'd6);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("keep_b[%0d]", j), 64'(got_bk[j]), (j == 5) ? 64'h03 : 64'hFF);
      chk($sformatf("last_b[%0d]", j), 64'(got_bl[j]), 64'(j == 5));
      for (int i = 0; i < 8; i++)
        if (j * 8 + i < 42)
          chk($sformatf("byte_b[%0d]", j*8+i), 64'(got_bd[j][8*i +: 8]), 64'(rep[j*8+i]));
    end
    chk("reply_cnt_b", 64'(rcnt_b), 64'd1);

    // Non-matching requests produce no reply and leave both counters alone
    for (int t = 0; t < 5; t++) begin
      frm = req;
      case (t)
        0: frm[41] = 8'h0B;
        1: frm[21] = 8'h02;
        2: frm[13] = 8'h00;
        default: ;
      endcase
      send_a((t == 3) ? 41 : 42, t == 4);
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("neg%0d_tvalid", t), 64'(m_vld_a), 64'd0);
      chk($sformatf("neg%0d_reply_cnt", t), 64'(rcnt_a), 64'd1);
      chk($sformatf("neg%0d_drop_cnt", t), 64'(dcnt_a), 64'd0);
    end

    // Random downstream ready at 30% duty
    frm = req;
    send_a(42, 1'b0);
    collect_a(30, nb);
    check_reply_a(nb);
    chk("reply_cnt_2", 64'(rcnt_a), 64'd2);

    // Second request while the first reply is stalled is dropped
    m_rdy_a = 1'b0;
    send_a(42, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("stalled_tvalid", 64'(m_vld_a), 64'd1);
    send_a(42, 1'b0);
    chk("drop_cnt_1", 64'(dcnt_a), 64'd1);
    chk("reply_cnt_stalled", 64'(rcnt_a), 64'd2);
    collect_a(100, nb);
    check_reply_a(nb);
    repeat (20) @(posedge clk);
    #1;
    chk("single_reply_tvalid", 64'(m_vld_a), 64'd0);
    chk("reply_cnt_3", 64'(rcnt_a), 64'd3);

    // Asynchronous reset in the middle of SEND
    frm = req;
    send_a(42, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_tvalid", 64'(m_vld_a), 64'd1);
    chk("pre_rst_tdata", 64'(m_data_a), 64'h22);
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 64'(m_vld_a), 64'd0);
    chk("arst_tdata", 64'(m_data_a), 64'd0);
    chk("arst_tkeep", 64'(m_keep_a), 64'd0);
    chk("arst_tlast", 64'(m_last_a), 64'd0);
    chk("arst_reply_cnt", 64'(rcnt_a), 64'd0);
    chk("arst_drop_cnt", 64'(dcnt_a), 64'd0);
    chk("arst_s_tready", 64'(s_rdy_a), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_a(42, 1'b0);
    collect_a(100, nb);
    check_reply_a(nb);
    chk("reply_cnt_after_rst", 64'(rcnt_a), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
